// File: rtl/video_pattern_gen.sv
// Video timing generator with selectable test patterns (colour bars, grey ramp,
// checkerboard, moving ramp) and registered RGB/sync outputs for a TMDS transmitter.
module video_pattern_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       dv,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are at least 8 bits wide so the pattern logic can always slice [7:0].
  localparam int unsigned HCW     = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int unsigned VCW     = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  localparam int unsigned BCW     = ($clog2(BAR_W) > 0) ? $clog2(BAR_W) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [HCW-1:0]   r_hcnt;
  logic [HCW-1:0]   w_hcnt_nxt;
  logic [VCW-1:0]   r_vcnt;
  logic [VCW-1:0]   w_vcnt_nxt;
  logic [7:0]       r_fcnt;
  logic [1:0]       r_mode_q;
  logic [BCW-1:0]   r_bar_cnt;
  logic [2:0]       r_bar_idx;
  logic             w_run;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_frame_wrap;
  logic             w_first_pix;
  logic             w_active;
  logic             w_hs_on;
  logic             w_vs_on;
  logic [1:0]       w_mode_eff;
  logic [7:0]       w_r;
  logic [7:0]       w_g;
  logic [7:0]       w_b;

  assign w_h_last     = (r_hcnt == HCW'(H_TOTAL - 1));
  assign w_v_last     = (r_vcnt == VCW'(V_TOTAL - 1));
  assign w_frame_wrap = w_h_last && w_v_last;

  // FSM: w_run marks a cycle whose (hcnt,vcnt) gets described on the outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt = S_RUN;
          w_run       = 1'b1;
        end
      end
      S_RUN: begin
        w_run = 1'b1;
        if (w_frame_wrap && !en) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_hcnt_nxt = r_hcnt;
    w_vcnt_nxt = r_vcnt;
    if (w_run) begin
      if (w_h_last) begin
        w_hcnt_nxt = '0;
        w_vcnt_nxt = w_v_last ? '0 : r_vcnt + VCW'(1);
      end else begin
        w_hcnt_nxt = r_hcnt + HCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_vcnt  <= w_vcnt_nxt;
    end
  end

  // Bar index tracks hcnt/BAR_W incrementally instead of dividing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (w_run) begin
      if (w_h_last) begin
        r_bar_cnt <= '0;
        r_bar_idx <= '0;
      end else if (r_bar_cnt == BCW'(BAR_W - 1)) begin
        r_bar_cnt <= '0;
        r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt   <= '0;
      r_mode_q <= '0;
    end else begin
      if (w_run && w_frame_wrap) r_fcnt <= r_fcnt + 8'd1;
      if (w_first_pix)           r_mode_q <= mode;
    end
  end

  assign w_first_pix = w_run && (r_hcnt == '0) && (r_vcnt == '0);
  // The first pixel of a frame already uses the mode being latched.
  assign w_mode_eff  = w_first_pix ? mode : r_mode_q;
  assign w_active    = (r_hcnt < HCW'(H_ACTIVE)) && (r_vcnt < VCW'(V_ACTIVE));
  assign w_hs_on     = (r_hcnt >= HCW'(H_ACTIVE + H_FP)) &&
                       (r_hcnt <  HCW'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_on     = (r_vcnt >= VCW'(V_ACTIVE + V_FP)) &&
                       (r_vcnt <  VCW'(V_ACTIVE + V_FP + V_SYNC));

  // Bar order white..black maps onto inverted index bits per component.
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (w_mode_eff)
      2'd0: begin
        w_r = {8{~r_bar_idx[1]}};
        w_g = {8{~r_bar_idx[2]}};
        w_b = {8{~r_bar_idx[0]}};
      end
      2'd1: begin
        w_r = r_hcnt[7:0];
        w_g = r_hcnt[7:0];
        w_b = r_hcnt[7:0];
      end
      2'd2: begin
        w_r = {8{r_hcnt[5] ^ r_vcnt[5]}};
        w_g = {8{r_hcnt[5] ^ r_vcnt[5]}};
        w_b = {8{r_hcnt[5] ^ r_vcnt[5]}};
      end
      default: begin
        w_r = r_hcnt[7:0] + r_fcnt;
        w_g = r_vcnt[7:0];
        w_b = r_fcnt;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      dv          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
    end else if (w_run) begin
      red         <= w_active ? w_r : 8'd0;
      green       <= w_active ? w_g : 8'd0;
      blue        <= w_active ? w_b : 8'd0;
      dv          <= w_active;
      hs          <= w_hs_on ? HS_POL : ~HS_POL;
      vs          <= w_vs_on ? VS_POL : ~VS_POL;
      frame_start <= w_first_pix;
    end else begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      dv          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen with small timing (H 16/2/2/2, V 4/1/1/1);
// a second instance with inverted sync polarity runs in parallel.
module tb_video_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] red, green, blue;
  logic       dv, hs, vs, fs;
  logic [7:0] red_b, green_b, blue_b;
  logic       dv_b, hs_b, vs_b, fs_b;

  int tests;
  int failed;

  localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .red(red), .green(green), .blue(blue),
    .dv(dv), .hs(hs), .vs(vs), .frame_start(fs)
  );

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .red(red_b), .green(green_b), .blue(blue_b),
    .dv(dv_b), .hs(hs_b), .vs(vs_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    tick();
    tests++;
    if ({red, green, blue, dv, hs, vs, fs} !== {24'h0, 4'b0000}) begin
      failed++;
      $display("FAIL reset_pos got rgb=%h dv/hs/vs/fs=%b%b%b%b exp rgb=000000 0000",
               {red, green, blue}, dv, hs, vs, fs);
    end
    tests++;
    if ({red_b, green_b, blue_b, dv_b, hs_b, vs_b, fs_b} !== {24'h0, 4'b0110}) begin
      failed++;
      $display("FAIL reset_neg got rgb=%h dv/hs/vs/fs=%b%b%b%b exp rgb=000000 0110",
               {red_b, green_b, blue_b}, dv_b, hs_b, vs_b, fs_b);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if ({dv, hs, vs, fs} !== 4'b0000) begin
      failed++;
      $display("FAIL idle_after_reset got %b exp 0000", {dv, hs, vs, fs});
    end
  endtask

  // Two full frames of colour bars; checks timing flags, bar colours and both polarities.
  task automatic test_bars();
    int h, v;
    logic [3:0]  exp_f;
    logic [23:0] exp_rgb;
    do_reset();
    en   = 1'b1;
    mode = 2'd0;
    tick();
    for (int i = 0; i < 308; i++) begin
      h = i % 22;
      v = (i / 22) % 7;
      exp_rgb = (h < 16 && v < 4) ? BAR_TAB[h / 2] : 24'h0;
      exp_f   = {(h < 16 && v < 4), (h >= 18 && h < 20), (v == 5), (i % 154 == 0)};
      tests++;
      if ({dv, hs, vs, fs} !== exp_f) begin
        failed++;
        $display("FAIL bars_flags i=%0d got %b exp %b", i, {dv, hs, vs, fs}, exp_f);
      end
      tests++;
      if ({red, green, blue} !== exp_rgb) begin
        failed++;
        $display("FAIL bars_rgb i=%0d got %h exp %h", i, {red, green, blue}, exp_rgb);
      end
      tests++;
      if ({dv_b, ~hs_b, ~vs_b, fs_b, red_b, green_b, blue_b} !== {exp_f, exp_rgb}) begin
        failed++;
        $display("FAIL bars_negpol i=%0d got %b %h exp %b %h", i,
                 {dv_b, hs_b, vs_b, fs_b}, {red_b, green_b, blue_b},
                 {exp_f[3], ~exp_f[2], ~exp_f[1], exp_f[0]}, exp_rgb);
      end
      tick();
    end
  endtask

  // Ramp frame with a mid-frame switch to mode 3, then 257 moving-ramp frames (fcnt wraps).
  task automatic test_mode_change();
    int h, v;
    logic        exp_dv;
    logic [23:0] exp_rgb;
    logic [7:0]  hf, f8;
    do_reset();
    en   = 1'b1;
    mode = 2'd1;
    tick();
    for (int f = 0; f < 258; f++) begin
      for (int i = 0; i < 154; i++) begin
        h  = i % 22;
        v  = i / 22;
        f8 = 8'(f);
        hf = 8'(h + f);
        exp_dv = (h < 16 && v < 4);
        if (!exp_dv)     exp_rgb = 24'h0;
        else if (f == 0) exp_rgb = {8'(h), 8'(h), 8'(h)};
        else             exp_rgb = {hf, 8'(v), f8};
        tests++;
        if ({dv, fs, red, green, blue} !== {exp_dv, (i == 0), exp_rgb}) begin
          failed++;
          $display("FAIL mode_rgb f=%0d i=%0d got dv=%b fs=%b rgb=%h exp dv=%b fs=%b rgb=%h",
                   f, i, dv, fs, {red, green, blue}, exp_dv, (i == 0), exp_rgb);
        end
        if (f == 0 && i == 77) mode = 2'd3;
        tick();
      end
    end
  endtask

  // en drops on line 2: frame must finish, then outputs idle, then restart after 1 clk.
  task automatic test_en_drop();
    int h, v;
    logic [3:0] exp_f;
    do_reset();
    en   = 1'b1;
    mode = 2'd2;
    tick();
    for (int i = 0; i < 154; i++) begin
      h = i % 22;
      v = i / 22;
      exp_f = {(h < 16 && v < 4), (h >= 18 && h < 20), (v == 5), (i == 0)};
      tests++;
      if ({dv, hs, vs, fs, red, green, blue} !== {exp_f, 24'h0}) begin
        failed++;
        $display("FAIL endrop_frame i=%0d got %b %h exp %b 000000", i,
                 {dv, hs, vs, fs}, {red, green, blue}, exp_f);
      end
      if (i == 44) en = 1'b0;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({dv, hs, vs, fs} !== 4'b0000 || {hs_b, vs_b} !== 2'b11) begin
        failed++;
        $display("FAIL endrop_idle i=%0d got %b %b%b exp 0000 11", i,
                 {dv, hs, vs, fs}, hs_b, vs_b);
      end
      tick();
    end
    en = 1'b1;
    tick();
    tests++;
    if ({dv, hs, vs, fs} !== 4'b1001) begin
      failed++;
      $display("FAIL endrop_restart got %b exp 1001", {dv, hs, vs, fs});
    end
    tick();
    tests++;
    if ({dv, fs} !== 2'b10) begin
      failed++;
      $display("FAIL endrop_second_pix got %b exp 10", {dv, fs});
    end
  endtask

  // Asynchronous reset at hcnt=7 of line 3, then restart latency after release.
  task automatic test_async_reset();
    do_reset();
    en   = 1'b1;
    mode = 2'd0;
    tick();
    for (int i = 0; i < 73; i++) tick();
    tests++;
    if ({dv, red, green, blue} !== {1'b1, 24'h00FF00}) begin
      failed++;
      $display("FAIL areset_pre got dv=%b rgb=%h exp dv=1 rgb=00ff00", dv, {red, green, blue});
    end
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    tests++;
    if ({red, green, blue, dv, hs, vs, fs} !== {24'h0, 4'b0000}) begin
      failed++;
      $display("FAIL areset_now got rgb=%h flags=%b exp 000000 0000",
               {red, green, blue}, {dv, hs, vs, fs});
    end
    tests++;
    if ({red_b, green_b, blue_b, dv_b, hs_b, vs_b, fs_b} !== {24'h0, 4'b0110}) begin
      failed++;
      $display("FAIL areset_now_neg got rgb=%h flags=%b exp 000000 0110",
               {red_b, green_b, blue_b}, {dv_b, hs_b, vs_b, fs_b});
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if ({dv, fs} !== 2'b00) begin
      failed++;
      $display("FAIL areset_idle got %b exp 00", {dv, fs});
    end
    en = 1'b1;
    tick();
    tests++;
    if ({dv, fs, red, green, blue} !== {2'b11, 24'hFFFFFF}) begin
      failed++;
      $display("FAIL areset_first_fs got dv/fs=%b rgb=%h exp 11 ffffff",
               {dv, fs}, {red, green, blue});
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    mode   = 2'd0;
    test_reset();
    test_bars();
    test_mode_change();
    test_en_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 1280, active pixels per line (multiple of 8)
- H_FP, 110, horizontal front porch in clocks
- H_SYNC, 40, horizontal sync width in clocks
- H_BP, 220, horizontal back porch in clocks
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch in lines
- V_SYNC, 5, vertical sync width in lines
- V_BP, 20, vertical back porch in lines
- HS_POL, 1, asserted level of hs
- VS_POL, 1, asserted level of vs
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock (same domain as tx_clk)
- rst_n, in, 1, reset, asynchronous, active-low
- en, in, 1, generator run enable
- mode, in, 2, pattern select
- red, out, 8, pixel red
- green, out, 8, pixel green
- blue, out, 8, pixel blue
- dv, out, 1, active-video flag
- hs, out, 1, horizontal sync
- vs, out, 1, vertical sync
- frame_start, out, 1, one-cycle pulse on the first pixel of a frame
REQ-003 Outputs SHALL drive hdmi_tx tx_red/tx_green/tx_blue/tx_dv/tx_hs/tx_vs directly, with no further adaptation.

Function
REQ-004 hcnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, and wrap to 0.
REQ-005 vcnt SHALL increment when hcnt wraps, count 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, and wrap to 0.
REQ-006 Timing decode:
- active = hcnt<H_ACTIVE and vcnt<V_ACTIVE
- hs asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC
- vs asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC
- vs edges coincide with hcnt=0
REQ-007 Asserted hs SHALL equal HS_POL and asserted vs SHALL equal VS_POL; deasserted levels are the inverse.
REQ-008 All outputs SHALL be registered, with exactly 1 clk of latency from the (hcnt,vcnt) they describe.
REQ-009 The FSM SHALL have states IDLE and RUN.
- IDLE: counters held at 0; outputs at reset values
- IDLE->RUN: en=1 sampled high
- RUN->IDLE: only at the frame wrap (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1) while en=0
- en dropping mid-frame SHALL complete the current frame
REQ-010 frame_start SHALL be 1 for the single cycle whose outputs describe hcnt=0, vcnt=0 in RUN.
REQ-011 mode SHALL be latched into mode_q at every frame start (including IDLE->RUN); a mid-frame change has no effect until the next frame.
REQ-012 Patterns for active pixels, by mode_q:
- 0: 8 colour bars, bar = hcnt/(H_ACTIVE/8), in order white, yellow, cyan, green, magenta, red, blue, black; components FF or 00
- 1: grey ramp, R=G=B=hcnt[7:0]
- 2: checkerboard, R=G=B = (hcnt[5]^vcnt[5]) ? FF : 00
- 3: moving ramp, R=hcnt[7:0]+fcnt (mod 256), G=vcnt[7:0], B=fcnt
REQ-013 fcnt SHALL be an 8-bit frame counter that increments at each frame wrap in RUN, wraps 255->0, and clears only on reset.
REQ-014 red/green/blue SHALL be 0 whenever dv=0.

Reset
REQ-015 rst_n=0 SHALL asynchronously force the following, including mid-frame:
- state=IDLE; hcnt=vcnt=fcnt=0; mode_q=0
- RGB=0; dv=0; frame_start=0
- hs=~HS_POL; vs=~VS_POL
REQ-016 After rst_n release, the first frame_start SHALL occur 1 clk after en is first sampled high.

Verification (small parameters: H 16/2/2/2, V 4/1/1/1, so H_TOTAL=22 and V_TOTAL=7)
REQ-017 Bench scenarios:
- reset, en=1, mode=0 -> frame_start every 154 clks; dv high 16 clks per line for 4 lines; bar k pixels = bar colour k for k=0..7
- same run, measure syncs -> hs high for hcnt 18..19; vs high for all of line 5
- mode 1->3 change at mid-frame -> pattern stays ramp until next frame_start; then B=fcnt and fcnt increments per frame, 255->0
- en=0 at line 2 -> frame completes; then dv/hs/vs idle; next en=1 -> frame_start after 1 clk
- rst_n low at hcnt=7 of line 3 -> all outputs at reset values immediately, without waiting for a clk edge
- HS_POL=0, VS_POL=0 -> sync waveforms inverted; dv and RGB unchanged
